// File: rtl/touch_button_array_if.sv
// Touch-sample and button-event bundle for touch_button_array.
// The master side drives samples and region bounds; the slave side returns button events.
interface touch_button_array_if #(
  parameter int NUM_BTN = 4,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);
  logic                   iREADY;
  logic [X_W-1:0]         ix1;
  logic [Y_W-1:0]         iy1;
  logic [X_W-1:0]         ix2;
  logic [Y_W-1:0]         iy2;
  logic [1:0]             itouch_count;
  logic [NUM_BTN*X_W-1:0] iX_MIN;
  logic [NUM_BTN*X_W-1:0] iX_MAX;
  logic [NUM_BTN*Y_W-1:0] iY_MIN;
  logic [NUM_BTN*Y_W-1:0] iY_MAX;
  logic [NUM_BTN-1:0]     oButton_state;
  logic [NUM_BTN-1:0]     oPress;
  logic [NUM_BTN-1:0]     oRelease;
  logic [NUM_BTN-1:0]     oRepeat;

  modport master (
    output iREADY, ix1, iy1, ix2, iy2, itouch_count,
    output iX_MIN, iX_MAX, iY_MIN, iY_MAX,
    input  oButton_state, oPress, oRelease, oRepeat
  );

  modport slave (
    input  iREADY, ix1, iy1, ix2, iy2, itouch_count,
    input  iX_MIN, iX_MAX, iY_MIN, iY_MAX,
    output oButton_state, oPress, oRelease, oRepeat
  );
endinterface

// File: rtl/touch_button_array.sv
// Maps up to two touch points onto NUM_BTN programmable regions: debounced level, press/release/repeat pulses.
// Optional macro TOUCH_TIMEOUT_EN adds an iREADY-silence watchdog that forces the touch count to zero.
module touch_button_array #(
  parameter int NUM_BTN        = 4,
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int DEB_CYCLES     = 4,
  parameter int HOLD_CYCLES    = 1000,
  parameter int REPEAT_CYCLES  = 200,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                 iCLK,
  input logic                 iRSTN,
  touch_button_array_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic [X_W-1:0]     x1_q, x2_q;
  logic [Y_W-1:0]     y1_q, y2_q;
  logic [1:0]         cnt_q;
  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] st_vec, press_vec, rel_vec, rep_vec;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      x1_q <= '0;
      y1_q <= '0;
      x2_q <= '0;
      y2_q <= '0;
    end else if (bus.iREADY) begin
      x1_q <= bus.ix1;
      y1_q <= bus.iy1;
      x2_q <= bus.ix2;
      y2_q <= bus.iy2;
    end
  end

`ifdef TOUCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_q;

  // Watchdog saturates at its terminal value and keeps the count forced to zero until iREADY returns.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      cnt_q <= '0;
      wd_q  <= '0;
    end else if (bus.iREADY) begin
      cnt_q <= bus.itouch_count;
      wd_q  <= '0;
    end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
      cnt_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN)
      cnt_q <= '0;
    else if (bus.iREADY)
      cnt_q <= bus.itouch_count;
  end
`endif

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      raw[k] = ((cnt_q != 2'd0) &&
                (bus.iX_MIN[k*X_W +: X_W] < x1_q) && (x1_q < bus.iX_MAX[k*X_W +: X_W]) &&
                (bus.iY_MIN[k*Y_W +: Y_W] < y1_q) && (y1_q < bus.iY_MAX[k*Y_W +: Y_W])) ||
               (cnt_q[1] &&
                (bus.iX_MIN[k*X_W +: X_W] < x2_q) && (x2_q < bus.iX_MAX[k*X_W +: X_W]) &&
                (bus.iY_MIN[k*Y_W +: Y_W] < y2_q) && (y2_q < bus.iY_MAX[k*Y_W +: Y_W]));
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    logic [DW-1:0] dcnt_q;
    logic          st_q, press_q, rel_q, rep_q, rep_d, toggle;
    rpt_state_t    rs_q, rs_d;
    logic [15:0]   hcnt_q, hcnt_d;

    assign toggle = (raw[g] != st_q) && (dcnt_q == DW'(DEB_CYCLES - 1));

    always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
        dcnt_q  <= '0;
        st_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= toggle & raw[g];
        rel_q   <= toggle & ~raw[g];
        if (raw[g] == st_q || toggle)
          dcnt_q <= '0;
        else
          dcnt_q <= dcnt_q + 1'b1;
        if (toggle)
          st_q <= raw[g];
      end
    end

    // The FSM reacts to the debounce toggle itself, so HELD starts on the same edge oPress rises.
    always_comb begin
      rs_d   = rs_q;
      hcnt_d = hcnt_q;
      rep_d  = 1'b0;
      if (toggle && !raw[g]) begin
        rs_d   = IDLE;
        hcnt_d = '0;
      end else begin
        case (rs_q)
          IDLE: begin
            if (toggle && raw[g]) begin
              rs_d   = HELD;
              hcnt_d = '0;
            end
          end
          HELD: begin
            if (hcnt_q == 16'(HOLD_CYCLES - 1)) begin
              rep_d  = 1'b1;
              hcnt_d = '0;
              rs_d   = REPEAT;
            end else begin
              hcnt_d = hcnt_q + 16'd1;
            end
          end
          REPEAT: begin
            if (hcnt_q == 16'(REPEAT_CYCLES - 1)) begin
              rep_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + 16'd1;
            end
          end
          default: begin
            rs_d   = IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
        rs_q   <= IDLE;
        hcnt_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        rs_q   <= rs_d;
        hcnt_q <= hcnt_d;
        rep_q  <= rep_d;
      end
    end

    assign st_vec[g]    = st_q;
    assign press_vec[g] = press_q;
    assign rel_vec[g]   = rel_q;
    assign rep_vec[g]   = rep_q;
  end

  assign bus.oButton_state = st_vec;
  assign bus.oPress        = press_vec;
  assign bus.oRelease      = rel_vec;
  assign bus.oRepeat       = rep_vec;
endmodule
